frame_buf_scanout: RTL and testbench
====================================

// Module: frame_buf_scanout
// PURPOSE
//  Read-side controller downstream of the frame-buffer data memory. On a start pulse it walks the
//  memory read port sequentially over one frame and turns the memory's registered read data into a
//  valid/ready pixel stream. Pixels carry start-of-frame and end-of-line markers for the display path.
//  It absorbs the 1-cycle memory read latency and sink back-pressure without dropping or duplicating pixels.
// PARAMETERS
//  DATA_WIDTH  16  pixel / memory word width
//  ADDR_WIDTH  3   memory address width; 2**ADDR_WIDTH >= H_ACTIVE*V_ACTIVE
//  H_ACTIVE    4   pixels per line
//  V_ACTIVE    2   lines per frame
//  BASE_ADDR   0   address of the first pixel of the frame
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  reset        in   1           synchronous, active-low
//  start        in   1           1-cycle pulse: begin scanning one frame (ignored unless IDLE)
//  mem_rd_en    out  1           memory read strobe, active-high
//  mem_rd_addr  out  ADDR_WIDTH  memory read address
//  mem_rd_data  in   DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
//  px_data      out  DATA_WIDTH  pixel value
//  px_valid     out  1           px_data/px_sof/px_eol are valid
//  px_ready     in   1           sink accepts; a transfer occurs when px_valid & px_ready
//  px_sof       out  1           first pixel of the frame
//  px_eol       out  1           last pixel of a line
//  busy         out  1           high from the cycle after an accepted start until frame_done
//  frame_done   out  1           1-cycle pulse after the last pixel transfers
// BEHAVIOUR
//  Reset (reset==0 at a posedge): state IDLE; mem_rd_en=0, mem_rd_addr=BASE_ADDR, px_valid=0,
//   px_sof=0, px_eol=0, px_data=0, busy=0, frame_done=0; FIFO and in-flight count cleared.
//   Reset mid-frame abandons the frame; the in-flight memory word is discarded.
//  FSM: IDLE -start-> RUN (issue reads) -last address issued-> DRAIN -last pixel transferred-> DONE
//   -> IDLE (frame_done=1 for that one cycle). start is ignored in RUN/DRAIN/DONE.
//  Issue rule: in RUN, mem_rd_en=1 only when FIFO occupancy + in-flight reads < 2 (credit check).
//   Address starts at BASE_ADDR and increments by 1 per issued read. The last read is at
//   BASE_ADDR+H_ACTIVE*V_ACTIVE-1. The address wraps modulo 2**ADDR_WIDTH.
//  Return: the cycle after mem_rd_en, mem_rd_data is pushed into a 2-entry FIFO. Tag bits are
//   computed at issue time and travel with the data: sof = first read; eol = column==H_ACTIVE-1.
//   Column and line counters are ADDR_WIDTH-sized and wrap to 0 at H_ACTIVE-1 / V_ACTIVE-1.
//  Output: px_valid = FIFO not empty; px_data/sof/eol come from the FIFO head.
//   Outputs hold stable while px_valid & !px_ready.
//  Latency: first px_valid is 2 cycles after start with px_ready=1. Steady throughput is
//   1 pixel/clk with ready held high. A ready deassert for N cycles stalls issue after at most
//   2 pending words.
//  Simultaneous push+pop on a full FIFO is legal; occupancy is unchanged.
//  Overflow is impossible by the credit rule; overflow must be asserted never to occur in sim.
//  busy stays high through DRAIN and DONE.
// STRUCTURE
//  Shared header fb_defs.vh: FSM state localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3)
//   and the common pixel-tag width (2 bits: sof, eol), also used by the upstream write path.
//  Sub-module fb_skid_fifo: 2-entry FIFO, width DATA_WIDTH+2, push/pop/full/empty, synchronous
//   active-low reset. The top level holds the FSM, address/column/line counters and credit logic.
// TESTING  (H_ACTIVE=4, V_ACTIVE=2, ADDR_WIDTH=3, memory preloaded addr k = 16'h00k0)
//  1 reset=0 two cycles, then reset=1 with no start -> all outputs 0, mem_rd_addr=0, busy=0 for 10 clks.
//  2 start pulse, px_ready=1 -> px_valid from start+2, data 0000,0010..0070 on 8 consecutive clks;
//    px_sof only on 0000; px_eol on 0030 and 0070; frame_done 1 clk after 0070 transfers; busy falls.
//  3 as 2, px_ready=0 for clks 3-8 -> at most 2 words pending, mem_rd_en=0 while stalled,
//    px_data held stable, full sequence still 0000..0070 with no gaps or repeats.
//  4 random px_ready (50%), 3 back-to-back frames (start the cycle after frame_done) -> 24 pixels
//    in order, per-frame sof/eol correct; starts pulsed during busy are ignored.
//  5 reset=0 asserted mid-frame after 3 pixels -> next clk all outputs at reset values; a new start
//    replays from 0000.
//  6 BASE_ADDR=6 -> addresses 6,7,0,1,...,5 (wrap); data order follows.

Source files
------------

// File: rtl/frame_buf_scanout_pkg.sv
// Shared definitions for the frame-buffer scan-out path: FSM states and pixel tag layout.
// Also used by the upstream write path for the common tag width.
package frame_buf_scanout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fb_state_t;

    localparam int unsigned TAG_WIDTH = 2;

    typedef struct packed {
        logic sof;
        logic eol;
    } px_tag_t;

endpackage

// File: rtl/frame_buf_scanout_if.sv
// Memory read port plus outgoing pixel stream of the scan-out controller.
interface frame_buf_scanout_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] px_data;
    logic                  px_valid;
    logic                  px_ready;
    logic                  px_sof;
    logic                  px_eol;

    modport master (
        output mem_rd_en, mem_rd_addr, px_data, px_valid, px_sof, px_eol,
        input  mem_rd_data, px_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, px_data, px_valid, px_sof, px_eol,
        output mem_rd_data, px_ready
    );
endinterface

// File: rtl/frame_buf_scanout_skid_fifo.sv
// Two-entry FIFO holding returned memory words (data + tags) in front of the pixel sink.
module fb_skid_fifo #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);

    no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop));
    no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));

endmodule

// File: rtl/frame_buf_scanout.sv
// Walks the frame-buffer read port over one frame and turns the registered read data
// into a back-pressured pixel stream tagged with start-of-frame / end-of-line.
module frame_buf_scanout
    import frame_buf_scanout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned H_ACTIVE   = 4,
    parameter int unsigned V_ACTIVE   = 2,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                frame_done,
    frame_buf_scanout_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] H_LAST = ADDR_WIDTH'(H_ACTIVE - 1);
    localparam logic [ADDR_WIDTH-1:0] V_LAST = ADDR_WIDTH'(V_ACTIVE - 1);

    fb_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]           addr, col, line;
    logic                            in_flight;
    px_tag_t                         tag_q, head_tag;
    logic                            issue, pop, last_issue, last_pop;
    logic                            fifo_full, fifo_empty;
    logic [1:0]                      occupancy, pending;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] push_word, head;

    assign occupancy  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign pop        = !fifo_empty && bus.px_ready;
    // A word leaving this cycle frees its slot now, which keeps issue going at 1 px/clk.
    assign pending    = occupancy + {1'b0, in_flight} - {1'b0, pop};
    assign last_issue = (col == H_LAST) && (line == V_LAST);
    assign last_pop   = pop && (occupancy == 2'd1) && !in_flight;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = (pending < 2'd2);
                if (issue && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || state == DONE) begin
            addr <= BASE;
            col  <= '0;
            line <= '0;
        end else if (issue) begin
            addr <= addr + 1'b1;
            if (col == H_LAST) begin
                col  <= '0;
                line <= (line == V_LAST) ? '0 : line + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_flight <= 1'b0;
            tag_q     <= '0;
        end else begin
            in_flight <= issue;
            if (issue) begin
                tag_q.sof <= (col == '0) && (line == '0);
                tag_q.eol <= (col == H_LAST);
            end
        end
    end

    assign push_word = {tag_q, bus.mem_rd_data};

    fb_skid_fifo #(
        .WIDTH(DATA_WIDTH + TAG_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_tag        = head[DATA_WIDTH +: TAG_WIDTH];
    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = addr;
    assign bus.px_valid    = !fifo_empty;
    assign bus.px_data     = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign bus.px_sof      = !fifo_empty && head_tag.sof;
    assign bus.px_eol      = !fifo_empty && head_tag.eol;
    assign busy            = (state != IDLE);
    assign frame_done      = (state == DONE);

endmodule

// File: tb/tb_frame_buf_scanout.sv
// Drives two scan-out instances (BASE_ADDR 0 and 6) with shared stimulus and checks each
// against a frame-level model of addresses, pixels, tags, busy and frame_done.
module tb_frame_buf_scanout;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int unsigned BASE = (g == 0) ? 0 : 6;

        frame_buf_scanout_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) ifc ();
        logic busy, frame_done;

        frame_buf_scanout #(
            .DATA_WIDTH(16),
            .ADDR_WIDTH(3),
            .H_ACTIVE(4),
            .V_ACTIVE(2),
            .BASE_ADDR(BASE)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .busy       (busy),
            .frame_done (frame_done),
            .bus        (ifc.master)
        );

        assign ifc.px_ready = ready;

        // frame memory: word at address k is 16'h00k0, registered read
        always @(posedge clk)
            if (ifc.mem_rd_en) ifc.mem_rd_data <= 16'(ifc.mem_rd_addr) << 4;

        int unsigned issued = 0;
        int unsigned sent   = 0;
        bit exp_busy = 0, exp_done = 0, post_rst = 0, held = 0;
        logic [17:0] held_px;

        always @(negedge clk) begin
            bit xfer;
            xfer = ifc.px_valid && ready;
            check($sformatf("u%0d.busy", g), 32'(busy), 32'(exp_busy));
            check($sformatf("u%0d.frame_done", g), 32'(frame_done), 32'(exp_done));
            if (post_rst || !exp_busy)
                check($sformatf("u%0d.idle_outs", g),
                      {9'd0, ifc.px_valid, ifc.mem_rd_en, ifc.mem_rd_addr, ifc.px_data, ifc.px_sof, ifc.px_eol},
                      {9'd0, 1'b0, 1'b0, 3'(BASE), 16'h0, 1'b0, 1'b0});
            if (held)
                check($sformatf("u%0d.stall_hold", g),
                      {13'd0, ifc.px_valid, ifc.px_data, ifc.px_sof, ifc.px_eol}, {13'd0, 1'b1, held_px});
            if (ifc.mem_rd_en) begin
                check($sformatf("u%0d.rd_addr", g), {28'd0, issued < 8, ifc.mem_rd_addr},
                      {28'd0, 1'b1, 3'((BASE + issued) % 8)});
                issued++;
            end
            if (xfer) begin
                check($sformatf("u%0d.pixel", g), {14'd0, ifc.px_data, ifc.px_sof, ifc.px_eol},
                      {14'd0, 16'(((BASE + sent) % 8) * 16), sent == 0, (sent % 4) == 3});
                sent++;
            end
            if (exp_busy)
                check($sformatf("u%0d.pending_le2", g), 32'(issued - sent <= 2), 32'd1);
            held    = ifc.px_valid && !ready;
            held_px = {ifc.px_data, ifc.px_sof, ifc.px_eol};
            if (!reset) begin
                exp_busy = 0; exp_done = 0; issued = 0; sent = 0; post_rst = 1; held = 0;
            end else begin
                post_rst = 0;
                if (exp_done) begin
                    exp_done = 0;
                    exp_busy = 0;
                end else if (exp_busy && xfer && sent == 8) begin
                    exp_done = 1;
                end else if (!exp_busy && start) begin
                    exp_busy = 1; issued = 0; sent = 0;
                end
            end
        end
    end

    task automatic wait_done(input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (u[0].frame_done) break;
            tick;
        end
        check("done_timeout", 32'(u[0].frame_done), 32'd1);
        tick;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        // reset and idle
        tick; tick;
        reset = 1'b1;
        repeat (10) tick;

        // full-rate frame: latency and gapless output
        ready = 1'b1;
        pulse_start;
        check("lat_e0", {u[0].ifc.px_valid, u[1].ifc.px_valid}, 2'b00);
        tick;
        check("lat_e1", {u[0].ifc.px_valid, u[1].ifc.px_valid}, 2'b00);
        tick;
        for (int k = 0; k < 8; k++) begin
            check("gapless", {u[0].ifc.px_valid, u[1].ifc.px_valid}, 2'b11);
            tick;
        end
        wait_done(20);

        // sink stall after the first words
        pulse_start;
        tick; tick;
        ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k >= 3)
                check("stall_no_rd", {u[0].ifc.mem_rd_en, u[1].ifc.mem_rd_en}, 2'b00);
            tick;
        end
        ready = 1'b1;
        wait_done(40);

        // three back-to-back frames, random ready, stray starts while busy
        for (int f = 0; f < 3; f++) begin
            bit seen;
            pulse_start;
            seen = 0;
            for (int i = 0; i < 300; i++) begin
                ready = 1'($urandom % 2);
                start = ($urandom % 5) == 0;
                tick;
                if (u[0].frame_done) begin
                    seen = 1;
                    break;
                end
            end
            start = 1'b0;
            check("rand_frame_timeout", 32'(seen), 32'd1);
            tick;
        end

        // reset mid-frame, then replay
        ready = 1'b1;
        pulse_start;
        for (int i = 0; i < 50; i++) begin
            if (u[0].sent >= 3) break;
            tick;
        end
        check("reached_3px", 32'(u[0].sent >= 3), 32'd1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("rst_busy", {u[0].busy, u[1].busy, u[0].ifc.px_valid, u[1].ifc.px_valid}, 4'b0000);
        tick;
        pulse_start;
        wait_done(40);

        repeat (3) tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
